// File: rtl/conv_reduce_sequencer_pkg.sv
// rtl/conv_reduce_sequencer_pkg.sv - shared conv definitions: state encoding and width defaults
// Purpose: constants shared by the convolution reduction logic.
// Ports: none (package).
package conv_reduce_sequencer_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_ACCUM  = 2'd1;
   localparam state_t ST_DRAIN  = 2'd2;
   localparam state_t ST_OUTPUT = 2'd3;

   localparam int ACCW_DEFAULT = 16;
   localparam int CNTW_DEFAULT = 8;

endpackage

// File: rtl/VX_adder_tree.sv
// rtl/VX_adder_tree.sv - registered N-input adder, one cycle latency
// Purpose: sums N DATAW-bit elements (wrapping modulo 2^DATAW) and registers the result.
// Ports:
//   clk    - clock
//   reset  - asynchronous, active-high reset
//   en     - capture the sum of dataIn this cycle
//   dataIn - N packed elements, element i at [(i+1)*DATAW-1 : i*DATAW]
//   dout   - registered sum
//   active - dout was updated on the last edge
module VX_adder_tree #(
   parameter int N     = 4,
   parameter int DATAW = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic [N*DATAW-1:0] dataIn,
   output logic [DATAW-1:0]   dout,
   output logic               active
);

   logic [DATAW-1:0] sum;

   always_comb begin
      sum = '0;
      for (int i = 0; i < N; i++) begin
         sum = sum + dataIn[i*DATAW +: DATAW];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout   <= '0;
         active <= 1'b0;
      end else begin
         active <= en;
         if (en) begin
            dout <= sum;
         end
      end
   end

endmodule

// File: rtl/conv_reduce_sequencer.sv
// rtl/conv_reduce_sequencer.sv - reduces a multi-chunk convolution window through the adder tree
// Purpose: accepts cfg_chunks chunks of N elements, sums each through the adder tree and
//          accumulates the partial sums onto cfg_bias; one ACCW-bit result per job.
// Ports:
//   clk, reset              - clock, asynchronous active-low reset
//   in_valid/in_ready       - chunk stream handshake, in_data = N packed elements
//   cfg_chunks, cfg_bias    - job configuration, sampled on the first chunk accept
//   abort                   - synchronous flush of the job in flight
//   out_valid/out_ready     - result handshake, out_data = reduced result
//   busy                    - a job is in progress
module conv_reduce_sequencer
   import conv_reduce_sequencer_pkg::*;
#(
   parameter int N     = 4,
   parameter int DATAW = 8,
   parameter int ACCW  = ACCW_DEFAULT,
   parameter int CNTW  = CNTW_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*DATAW-1:0] in_data,
   input  logic [CNTW-1:0]    cfg_chunks,
   input  logic [ACCW-1:0]    cfg_bias,
   input  logic               abort,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ACCW-1:0]    out_data,
   output logic               busy
);

   state_t            state;
   state_t            state_next;
   logic [ACCW-1:0]   acc;
   logic [ACCW-1:0]   acc_sum;
   logic [CNTW-1:0]   cnt;
   logic [CNTW-1:0]   cnt_inc;
   logic [CNTW-1:0]   total;
   logic [CNTW-1:0]   first_total;
   logic              accept;
   logic              flush;
   logic [DATAW-1:0]  tree_dout;
   logic              tree_active;

   assign accept      = in_valid & in_ready;
   assign flush       = abort & (state != ST_IDLE);
   assign first_total = (cfg_chunks == '0) ? CNTW'(1) : cfg_chunks;
   assign cnt_inc     = cnt + CNTW'(1);
   // Tree results only count while a job is collecting them.
   assign acc_sum     = tree_active ? acc + ACCW'(tree_dout) : acc;

   VX_adder_tree #(
      .N     (N),
      .DATAW (DATAW)
   ) u_tree (
      .clk    (clk),
      .reset  (~reset),
      .en     (accept),
      .dataIn (in_data),
      .dout   (tree_dout),
      .active (tree_active)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state_next = (first_total == CNTW'(1)) ? ST_DRAIN : ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (accept && (cnt_inc == total)) begin
                  state_next = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               state_next = ST_OUTPUT;
            end
            default: begin
               if (out_ready) begin
                  state_next = ST_IDLE;
               end
            end
         endcase
      end
   end

   always_comb begin
      // in_ready is combinational on reset so the port drops the instant reset asserts.
      in_ready  = reset & ~abort & ((state == ST_IDLE) | (state == ST_ACCUM));
      out_valid = (state == ST_OUTPUT);
      busy      = (state != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc      <= '0;
         cnt      <= '0;
         total    <= '0;
         out_data <= '0;
      end else if (flush) begin
         acc <= '0;
         cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  total <= first_total;
                  cnt   <= CNTW'(1);
                  acc   <= cfg_bias;
               end
            end
            ST_ACCUM: begin
               if (accept) begin
                  cnt <= cnt_inc;
               end
               acc <= acc_sum;
            end
            ST_DRAIN: begin
               // The last chunk's tree sum lands here; the result includes it.
               acc      <= acc_sum;
               out_data <= acc_sum;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
